// File: rtl/pipe_data_mem_if.sv
// Handshake/bus bundle for the MEM-stage data memory, plus the shared
// access-type encodings used by the core and by this block.

`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_UB  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_SB  3'd4
`endif

interface pipe_data_mem_if;
    logic                  req;
    logic                  ready;
    logic [`DM_OP_BIT-1:0] op;
    logic                  w_en;
    logic [31:0]           addr;
    logic [31:0]           data_in;
    logic [31:0]           data;
    logic                  data_valid;
    logic                  misalign;
    logic [31:0]           addr_dbg;
    logic [31:0]           data_dbg;

    modport master (
        output req, op, w_en, addr, data_in, addr_dbg,
        input  ready, data, data_valid, misalign, data_dbg
    );

    modport slave (
        input  req, op, w_en, addr, data_in, addr_dbg,
        output ready, data, data_valid, misalign, data_dbg
    );
endinterface

// File: rtl/pipe_data_mem.sv
// MEM-stage data memory: byte/half/word stores via byte enables, zero/sign
// extended loads with one-cycle latency, misalignment suppression, optional
// post-reset clearing sweep and a registered debug read port.
//
// state | meaning
// CLEAR | sweeping zeros through every word, requests ignored
// IDLE  | ready, one access accepted per cycle

module pipe_data_mem #(
    parameter int ADDR_BITS      = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic            clk,
    input logic            rst,
    pipe_data_mem_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS:0]   clr_cnt, clr_cnt_nxt;
    logic                 clr_en;
    logic                 ready;

    logic [31:0]          mem [DEPTH];

    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] dbg_idx;
    logic                 accept;
    logic                 aligned;
    logic [3:0]           be;
    logic [3:0]           be_eff;
    logic [31:0]          wdata;
    logic [31:0]          rd_word;
    logic [15:0]          rd_half;
    logic [7:0]           rd_byte;
    logic [31:0]          load_val;
    logic                 unused_bits;

    assign idx     = bus.addr[ADDR_BITS+1:2];
    assign dbg_idx = bus.addr_dbg[ADDR_BITS+1:2];
    assign accept  = bus.req & ready;
    assign bus.ready = ready;

    // Upper address bits wrap by design; debug port only sees whole words.
    assign unused_bits = ^{bus.addr[31:ADDR_BITS+2], bus.addr_dbg[31:ADDR_BITS+2],
                           bus.addr_dbg[1:0]};

    // State register and clear counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state, sweep counter and handshake.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_en      = 1'b0;
        ready       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_en      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == (ADDR_BITS+1)'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Alignment, byte enables and lane-replicated store data per access type.
    always_comb begin
        aligned = 1'b1;
        be      = 4'b0000;
        wdata   = bus.data_in;
        case (bus.op)
            `DM_OP_WD: begin
                aligned = (bus.addr[1:0] == 2'b00);
                be      = 4'b1111;
            end
            `DM_OP_UH, `DM_OP_SH: begin
                aligned = ~bus.addr[0];
                be      = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.data_in[15:0]}};
            end
            `DM_OP_UB, `DM_OP_SB: begin
                be      = 4'b0001 << bus.addr[1:0];
                wdata   = {4{bus.data_in[7:0]}};
            end
            default: begin
                be      = 4'b0000;
            end
        endcase
        be_eff = (accept & bus.w_en & aligned) ? be : 4'b0000;
    end

    // Lane selection and extension of the addressed word for loads.
    always_comb begin
        rd_word  = mem[idx];
        rd_half  = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte  = rd_word[{bus.addr[1:0], 3'b000} +: 8];
        load_val = 32'h0;
        case (bus.op)
            `DM_OP_WD: load_val = rd_word;
            `DM_OP_UH: load_val = {16'h0, rd_half};
            `DM_OP_SH: load_val = {{16{rd_half[15]}}, rd_half};
            `DM_OP_UB: load_val = {24'h0, rd_byte};
            `DM_OP_SB: load_val = {{24{rd_byte[7]}}, rd_byte};
            default:   load_val = 32'h0;
        endcase
    end

    // Storage array: clearing sweep or byte-enabled store; contents survive rst.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt[ADDR_BITS-1:0]] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be_eff[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered load result, status pulses and read-first debug port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data       <= 32'h0;
            bus.data_valid <= 1'b0;
            bus.misalign   <= 1'b0;
            bus.data_dbg   <= 32'h0;
        end else begin
            bus.data_valid <= accept & ~bus.w_en & aligned;
            bus.misalign   <= accept & ~aligned;
            if (accept & ~bus.w_en) begin
                bus.data <= aligned ? load_val : 32'h0;
            end
            bus.data_dbg <= mem[dbg_idx];
        end
    end

endmodule

// File: tb/tb_pipe_data_mem.sv
// Randomized and directed checks of pipe_data_mem (ADDR_BITS=4, clearing on)
// against a word-array reference model of the access rules.

`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_UB  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_SB  3'd4
`endif

module tb_pipe_data_mem;

    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    pipe_data_mem_if bus ();

    pipe_data_mem #(.ADDR_BITS(AB), .CLEAR_ON_RESET(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int op_size(input logic [2:0] o);
        case (o)
            `DM_OP_WD:            return 4;
            `DM_OP_UH, `DM_OP_SH: return 2;
            `DM_OP_UB, `DM_OP_SB: return 1;
            default:              return 0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] o, input logic [31:0] a);
        int sz = op_size(o);
        if (sz == 0) return 1'b1;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int          sh;
        w  = mem_m[widx(a)];
        sh = 8 * int'(a % 4);
        v  = w >> sh;
        case (o)
            `DM_OP_WD: return w;
            `DM_OP_UH: return v & 32'hFFFF;
            `DM_OP_SH: return 32'(signed'(v[15:0]));
            `DM_OP_UB: return v & 32'hFF;
            `DM_OP_SB: return 32'(signed'(v[7:0]));
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int          sz = op_size(o);
        int          sh;
        logic [31:0] m;
        if (sz == 0) return;
        if (sz == 4) begin
            mem_m[widx(a)] = d;
            return;
        end
        sh = 8 * int'(a % 4);
        m  = (sz == 2) ? 32'hFFFF : 32'hFF;
        mem_m[widx(a)] = (mem_m[widx(a)] & ~(m << sh)) | ((d & m) << sh);
    endtask

    // One cycle in IDLE: drive, predict from the model, clock, check.
    task automatic do_cycle(input logic r, input logic [2:0] o, input logic we,
                            input logic [31:0] a, input logic [31:0] din,
                            input logic [31:0] dbg);
        logic        al;
        logic [31:0] exp_dbg;
        logic        exp_dv;
        logic        exp_mis;
        bus.req      = r;
        bus.op       = o;
        bus.w_en     = we;
        bus.addr     = a;
        bus.data_in  = din;
        bus.addr_dbg = dbg;
        al      = is_aligned(o, a);
        exp_dbg = mem_m[widx(dbg)];
        exp_dv  = r && !we && al;
        exp_mis = r && !al;
        if (r && !we) exp_data = al ? model_load(o, a) : 32'h0;
        @(posedge clk);
        #1;
        if (r && we && al) model_store(o, a, din);
        chk("ready", {31'h0, bus.ready}, 32'h1);
        chk("data_valid", {31'h0, bus.data_valid}, {31'h0, exp_dv});
        chk("misalign", {31'h0, bus.misalign}, {31'h0, exp_mis});
        chk("data", bus.data, exp_data);
        chk("data_dbg", bus.data_dbg, exp_dbg);
    endtask

    // Counts cycles until ready rises; pulses must stay low meanwhile.
    task automatic wait_clear(input string tag);
        int n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready) break;
            chk({tag, "_dv"}, {31'h0, bus.data_valid}, 32'h0);
            chk({tag, "_mis"}, {31'h0, bus.misalign}, 32'h0);
        end
        chk({tag, "_len"}, 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        exp_data = 32'h0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = 1'b0;
        bus.op       = `DM_OP_WD;
        bus.w_en     = 1'b0;
        bus.addr     = 32'h0;
        bus.data_in  = 32'h0;
        bus.addr_dbg = 32'h0;
        exp_data     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_data", bus.data, 32'h0);
        chk("rst_dv", {31'h0, bus.data_valid}, 32'h0);
        chk("rst_mis", {31'h0, bus.misalign}, 32'h0);
        chk("rst_dbg", bus.data_dbg, 32'h0);

        // Partial sweep interrupted by reset at cycle 8; sweep restarts.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("clr_ready", {31'h0, bus.ready}, 32'h0);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        wait_clear("clear1");

        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'(i * 4));

        // Directed lane extraction on 0xDEADBEEF.
        do_cycle(1'b1, `DM_OP_WD, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
        do_cycle(1'b1, `DM_OP_SB, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("ld_sb", bus.data, 32'hFFFFFFEF);
        do_cycle(1'b1, `DM_OP_UB, 1'b0, 32'h11, 32'h0, 32'h0);
        chk("ld_ub", bus.data, 32'h000000BE);
        do_cycle(1'b1, `DM_OP_SH, 1'b0, 32'h12, 32'h0, 32'h0);
        chk("ld_sh", bus.data, 32'hFFFFDEAD);
        do_cycle(1'b1, `DM_OP_UH, 1'b0, 32'h12, 32'h0, 32'h0);
        chk("ld_uh", bus.data, 32'h0000DEAD);
        do_cycle(1'b1, `DM_OP_WD, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("ld_wd", bus.data, 32'hDEADBEEF);

        // Partial stores leave other lanes untouched.
        do_cycle(1'b1, `DM_OP_WD, 1'b1, 32'h10, 32'h11223344, 32'h0);
        do_cycle(1'b1, `DM_OP_UB, 1'b1, 32'h13, 32'hFFFFFF55, 32'h0);
        do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'h10);
        chk("st_ub", bus.data_dbg, 32'h55223344);
        do_cycle(1'b1, `DM_OP_SH, 1'b1, 32'h12, 32'h0000ABCD, 32'h0);
        do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'h10);
        chk("st_sh", bus.data_dbg, 32'hABCD3344);

        // Misaligned accesses are suppressed.
        do_cycle(1'b1, `DM_OP_WD, 1'b1, 32'h0C, 32'h12345678, 32'h0);
        do_cycle(1'b1, `DM_OP_WD, 1'b0, 32'h0E, 32'h0, 32'h0);
        chk("mis_ld_data", bus.data, 32'h0);
        do_cycle(1'b1, `DM_OP_UH, 1'b1, 32'h0F, 32'hFFFFFFFF, 32'h0C);
        do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'h0C);
        chk("mis_st_mem", bus.data_dbg, 32'h12345678);

        // Read-first debug port and address aliasing.
        do_cycle(1'b1, `DM_OP_WD, 1'b1, 32'h20, 32'h1, 32'h20);
        chk("dbg_old", bus.data_dbg, 32'h0);
        do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'h20);
        chk("dbg_new", bus.data_dbg, 32'h1);
        do_cycle(1'b1, `DM_OP_WD, 1'b0, 32'h60, 32'h0, 32'h0);
        chk("alias", bus.data, 32'h1);

        // Random traffic, including undefined op codes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), a, $urandom, $urandom);
        end

        // Reset during an access cancels the pending pulse immediately.
        do_cycle(1'b1, `DM_OP_WD, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("pre_rst_dv", {31'h0, bus.data_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dv", {31'h0, bus.data_valid}, 32'h0);
        chk("mid_rst_data", bus.data, 32'h0);
        chk("mid_rst_ready", {31'h0, bus.ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Stores held during the sweep are dropped.
        bus.req     = 1'b1;
        bus.w_en    = 1'b1;
        bus.op      = `DM_OP_WD;
        bus.addr    = 32'h24;
        bus.data_in = 32'hFFFFFFFF;
        rst = 1'b0;
        wait_clear("clear2");
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, `DM_OP_WD, 1'b0, 32'h0, 32'h0, 32'(i * 4));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
